bcd_scan_display: RTL and testbench

- Parametrised successor to the team's fixed 3-digit seven-segment driver.
- Accepts a binary value and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Time-multiplexes NDIG digits onto a shared active-low segment bus, with configurable refresh period, optional leading-zero blanking and overflow indication.
- Sits between the datapath result registers and the board anode/segment pins.

---
 rtl/bcd_scan_display.sv | 169 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Binary to BCD converter (sequential double-dabble) feeding a time-multiplexed
// seven-segment scanner with leading-zero blanking and overflow dashes.
//
// state  | meaning
// S_IDLE | waiting for LOAD; BCD/OVF hold the last result
// S_CONV | shifting one BIN bit per cycle into the working digits
module bcd_scan_display #(
    parameter int BW      = 8,
    parameter int NDIG    = 3,
    parameter int REFRESH = 100000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [BW-1:0]       BIN,
    input  logic                LOAD,
    input  logic                LZB,
    input  logic                EN,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVF,
    output logic [4*NDIG-1:0]   BCD,
    output logic [NDIG-1:0]     ANODE,
    output logic [6:0]          SEG
);
    localparam int DW = 4 * NDIG;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam int TW = $clog2(REFRESH);
    localparam int SW = $clog2(NDIG);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NDIG - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t          state, state_next;
    logic            accept, finish;
    logic [BW-1:0]   shreg;
    logic [DW-1:0]   work, work_adj, work_shift;
    logic [CW-1:0]   cnt;
    logic            ovf_next, bin_over;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   sel;
    logic [3:0]      cur_nib;
    logic            blank, upper_zero;
    logic [NDIG-1:0] anode_next;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111110;
        endcase
    endfunction

    // Wide compare so a BW too narrow to reach 10^NDIG simply never overflows.
    assign bin_over = ({32'd0, BIN} > {{BW{1'b0}}, MAX_VAL});
    assign BUSY     = (state == S_CONV);

    // Conversion state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state: accept LOAD only when idle, finish on the last bit.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: if (LOAD) begin
                accept     = 1'b1;
                state_next = S_CONV;
            end
            S_CONV: if (cnt == '0) begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next BIN bit.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < NDIG; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        work_shift = {work_adj[DW-2:0], shreg[BW-1]};
    end

    // Conversion datapath and result registers; BCD changes only on completion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shreg    <= '0;
            work     <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            BCD      <= '0;
            OVF      <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= finish;
            if (accept) begin
                shreg    <= BIN;
                work     <= '0;
                cnt      <= CW'(BW - 1);
                ovf_next <= bin_over;
            end else if (BUSY) begin
                shreg <= shreg << 1;
                work  <= work_shift;
                cnt   <= cnt - 1'b1;
                if (finish) begin
                    BCD <= ovf_next ? '1 : work_shift;
                    OVF <= ovf_next;
                end
            end
        end
    end

    // Refresh timer and digit select; free-running regardless of EN/BUSY.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer <= '0;
            sel   <= '0;
        end else if (timer == TW'(REFRESH - 1)) begin
            timer <= '0;
            sel   <= (sel == SW'(NDIG - 1)) ? '0 : sel + 1'b1;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Pick the selected nibble and decide blanking (digit blank if it and all above are zero).
    always_comb begin
        cur_nib    = BCD[3:0];
        blank      = 1'b0;
        upper_zero = 1'b1;
        anode_next = '1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (BCD[4*i +: 4] == 4'd0);
            if (sel == SW'(i)) begin
                cur_nib       = BCD[4*i +: 4];
                blank         = LZB && !OVF && (i != 0) && upper_zero;
                anode_next[i] = 1'b0;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ANODE <= '1;
            SEG   <= 7'b1111111;
        end else if (!EN) begin
            ANODE <= '1;
            SEG   <= 7'b1111111;
        end else begin
            ANODE <= anode_next;
            SEG   <= blank ? 7'b1111111 : seg_of(cur_nib);
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised bench for bcd_scan_display: one 3-digit and one 2-digit instance,
// both with REFRESH=4, compared against a decimal-arithmetic display model.
module tb_bcd_scan_display;
    localparam int BW  = 8;
    localparam int REF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  bin3, bin2;
    logic        load3, load2, lzb, en;
    logic        busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    logic [2:0]  anode3;
    logic [1:0]  anode2;
    logic [6:0]  seg3, seg2;

    bcd_scan_display #(.BW(BW), .NDIG(3), .REFRESH(REF)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .BIN(bin3), .LOAD(load3), .LZB(lzb), .EN(en),
        .BUSY(busy3), .DONE(done3), .OVF(ovf3), .BCD(bcd3), .ANODE(anode3), .SEG(seg3));

    bcd_scan_display #(.BW(BW), .NDIG(2), .REFRESH(REF)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .BIN(bin2), .LOAD(load2), .LZB(lzb), .EN(en),
        .BUSY(busy2), .DONE(done2), .OVF(ovf2), .BCD(bcd2), .ANODE(anode2), .SEG(seg2));

    int total = 0;
    int bad   = 0;
    int nedge;
    int mval [2];
    logic [6:0] seg_tab [0:15];

    // Edges seen since reset release; drives the scan position model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nedge <= 0;
        else        nedge <= nedge + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    function automatic logic [31:0] model_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++)
            r[4*i +: 4] = (v > pow10(nd) - 1) ? 4'hF : 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int nd, input int d,
                                             input logic lz, input logic en_i);
        if (!en_i) return 7'b1111111;
        if (v > pow10(nd) - 1) return 7'b1111110;
        if (lz && d > 0 && v < pow10(d)) return 7'b1111111;
        return seg_tab[(v / pow10(d)) % 10];
    endfunction

    function automatic int ndig_of(input int which);
        return (which == 0) ? 3 : 2;
    endfunction

    // Check ANODE/SEG for a number of cycles against the scan/decode model.
    task automatic window(input int which, input int cycles);
        int nd, s;
        logic [31:0] want_an, got_an, got_seg;
        nd = ndig_of(which);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            s = ((nedge - 1) / REF) % nd;
            want_an = (nedge == 0 || !en) ? (32'd1 << nd) - 1 : ((32'd1 << nd) - 1) ^ (32'd1 << s);
            got_an  = (which == 0) ? {29'd0, anode3} : {30'd0, anode2};
            got_seg = (which == 0) ? {25'd0, seg3} : {25'd0, seg2};
            check_val("anode", got_an, want_an);
            check_val("seg", got_seg, {25'd0, model_seg(mval[which], nd, s, lzb, en)});
        end
    endtask

    // Full conversion with per-cycle BUSY/DONE timing and result checks.
    task automatic convert(input int which, input int v);
        int nd;
        nd = ndig_of(which);
        @(negedge clk);
        if (which == 0) begin bin3 = v[7:0]; load3 = 1'b1; end
        else            begin bin2 = v[7:0]; load2 = 1'b1; end
        @(negedge clk);
        load3 = 1'b0;
        load2 = 1'b0;
        for (int c = 1; c <= BW; c++) begin
            if (c > 1) @(negedge clk);
            check_val("busy_done_conv", (which == 0) ? {30'd0, busy3, done3} : {30'd0, busy2, done2}, 32'd2);
        end
        @(negedge clk);
        check_val("busy_done_end", (which == 0) ? {30'd0, busy3, done3} : {30'd0, busy2, done2}, 32'd1);
        check_val("bcd", (which == 0) ? {20'd0, bcd3} : {24'd0, bcd2}, model_bcd(v, nd));
        check_val("ovf", (which == 0) ? {31'd0, ovf3} : {31'd0, ovf2}, {31'd0, (v > pow10(nd) - 1)});
        mval[which] = v;
        @(negedge clk);
        check_val("done_pulse", (which == 0) ? {31'd0, done3} : {31'd0, done2}, 32'd0);
    endtask

    initial begin
        int v, ndone, nbusy;
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111110;
        mval[0] = 0; mval[1] = 0;
        bin3 = '0; bin2 = '0; load3 = 1'b0; load2 = 1'b0; lzb = 1'b0; en = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_status", {29'd0, busy3, done3, ovf3}, 32'd0);
        check_val("rst_bcd", {20'd0, bcd3}, 32'd0);
        check_val("rst_anode", {29'd0, anode3}, 32'h7);
        check_val("rst_seg", {25'd0, seg3}, 32'h7F);
        rst_n = 1'b1;

        window(0, 14);
        convert(0, 205);
        window(0, 13);
        lzb = 1'b1;
        convert(0, 7);
        window(0, 13);
        convert(0, 0);
        window(0, 13);

        for (int r = 0; r < 6; r++) begin
            lzb = 1'($urandom_range(0, 1));
            convert(0, int'($urandom_range(0, 255)));
            window(0, 13);
        end

        @(negedge clk);
        en = 1'b0;
        window(0, 7);
        en = 1'b1;
        window(0, 13);

        // Second LOAD during a conversion must be dropped.
        lzb = 1'b1;
        @(negedge clk);
        bin3 = 8'd99; load3 = 1'b1;
        ndone = 0; nbusy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            load3 = 1'b0;
            if (c == 4) begin bin3 = 8'd250; load3 = 1'b1; end
            if (done3) ndone++;
            if (busy3) nbusy++;
        end
        load3 = 1'b0;
        check_val("ign_done_count", ndone, 1);
        check_val("ign_busy_cycles", nbusy, BW);
        check_val("ign_bcd", {20'd0, bcd3}, 32'h099);
        mval[0] = 99;
        window(0, 13);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin3 = 8'd123; load3 = 1'b1;
        @(negedge clk);
        load3 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_status", {29'd0, busy3, done3, ovf3}, 32'd0);
        check_val("abort_bcd", {20'd0, bcd3}, 32'd0);
        check_val("abort_anode", {29'd0, anode3}, 32'h7);
        check_val("abort_seg", {25'd0, seg3}, 32'h7F);
        mval[0] = 0; mval[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        check_val("abort_no_done", ndone, 0);
        check_val("abort_bcd_hold", {20'd0, bcd3}, 32'd0);
        lzb = 1'b0;
        window(0, 13);

        // Two-digit instance: overflow dashes, recovery, random values.
        convert(1, 150);
        window(1, 10);
        convert(1, 42);
        window(1, 10);
        for (int r = 0; r < 5; r++) begin
            lzb = 1'($urandom_range(0, 1));
            v = int'($urandom_range(0, 255));
            convert(1, v);
            window(1, 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
